// File: rtl/sld_acq_capture_ctrl_if.sv
// ----------------------------------------------------------------------------
// sld_acq_capture_ctrl_if
//   Write port of the capture sample RAM. The acquisition sequencer drives it
//   through the master modport. The RAM or any observer uses the slave modport.
//
//   mem_we     RAM write enable
//   mem_waddr  RAM write address (ADDR_BITS)
//   mem_wdata  RAM write data    (DATA_BITS)
// ----------------------------------------------------------------------------
interface sld_acq_capture_ctrl_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 7
);
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [DATA_BITS-1:0] mem_wdata;

    modport master (output mem_we, output mem_waddr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_waddr, input  mem_wdata);
endinterface

// File: rtl/sld_acq_capture_ctrl.sv
// ----------------------------------------------------------------------------
// sld_acq_capture_ctrl
//   Acquisition sequencer for a signal-tap style capture buffer.
//   - An arm request starts a run.
//   - Samples are stored circularly into an external RAM.
//   - A masked trigger pattern is detected.
//   - A programmable number of post-trigger samples is stored.
//   - The block then stops and holds irq high.
//
//   Optional feature: when SLD_ACQ_STORAGE_QUAL_EN is defined, storage_enable
//   qualifies every store. A cycle with storage_enable=0 does not write, does
//   not advance the pointer, does not decrement the counter and does not
//   accept a trigger. When the macro is undefined, every cycle in ARMED or
//   POST stores.
//
// Ports
//   acq_clk            acquisition clock, rising edge
//   clrn               asynchronous active-low reset
//   arm / abort        1-cycle control pulses (abort has priority)
//   trigger_mask/value masked trigger pattern (quasi-static)
//   post_trigger_count samples stored after the trigger sample, sampled on arm
//   acq_trigger_in     trigger tap
//   acq_data_in        data tap
//   storage_enable     storage qualifier (used only with the optional feature)
//   mem                RAM write port (registered, one cycle after the sample)
//   trigger_out        1-cycle pulse when a trigger is accepted
//   trigger_addr       RAM address that holds the trigger sample
//   wrapped            write pointer has wrapped during this run
//   busy               run in progress (ARMED or POST)
//   irq                run complete (DONE)
// ----------------------------------------------------------------------------
module sld_acq_capture_ctrl #(
    parameter int SLD_DATA_BITS        = 8,
    parameter int SLD_TRIGGER_BITS     = 8,
    parameter int SLD_MEM_ADDRESS_BITS = 7
) (
    input  logic                            acq_clk,
    input  logic                            clrn,
    input  logic                            arm,
    input  logic                            abort,
    input  logic [SLD_TRIGGER_BITS-1:0]     trigger_mask,
    input  logic [SLD_TRIGGER_BITS-1:0]     trigger_value,
    input  logic [SLD_MEM_ADDRESS_BITS-1:0] post_trigger_count,
    input  logic [SLD_TRIGGER_BITS-1:0]     acq_trigger_in,
    input  logic [SLD_DATA_BITS-1:0]        acq_data_in,
    input  logic                            storage_enable,
    sld_acq_capture_ctrl_if.master          mem,
    output logic                            trigger_out,
    output logic [SLD_MEM_ADDRESS_BITS-1:0] trigger_addr,
    output logic                            wrapped,
    output logic                            busy,
    output logic                            irq
);
    localparam int A = SLD_MEM_ADDRESS_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   state_reg;
    logic [A-1:0]             ptr_reg;
    logic [A-1:0]             post_cnt_reg;
    logic [A-1:0]             trigger_addr_reg;
    logic                     wrapped_reg;
    logic                     trigger_out_reg;
    logic                     mem_we_reg;
    logic [A-1:0]             mem_waddr_reg;
    logic [SLD_DATA_BITS-1:0] mem_wdata_reg;

    logic qual;
    logic hit;
    logic store;

`ifdef SLD_ACQ_STORAGE_QUAL_EN
    assign qual = storage_enable;
`else
    logic unused_storage_enable;
    assign unused_storage_enable = storage_enable;
    assign qual = 1'b1;
`endif

    // An all-zero mask makes every cycle a hit.
    assign hit   = ((acq_trigger_in ^ trigger_value) & trigger_mask) == '0;
    assign store = ((state_reg == ST_ARMED) || (state_reg == ST_POST)) && qual;

    // post_trigger_count is A bits wide, so it can never exceed D-1.
    // The trigger sample therefore can never be overwritten by a post sample,
    // and no explicit clamp is needed.
    always_ff @(posedge acq_clk or negedge clrn) begin
        if (!clrn) begin
            state_reg        <= ST_IDLE;
            ptr_reg          <= '0;
            post_cnt_reg     <= '0;
            trigger_addr_reg <= '0;
            wrapped_reg      <= 1'b0;
            trigger_out_reg  <= 1'b0;
            mem_we_reg       <= 1'b0;
            mem_waddr_reg    <= '0;
            mem_wdata_reg    <= '0;
        end else begin
            trigger_out_reg <= 1'b0;
            mem_we_reg      <= 1'b0;
            if (abort) begin
                state_reg <= ST_IDLE;
            end else if (arm) begin
                // A restart from any state behaves exactly like arming from IDLE.
                state_reg        <= ST_ARMED;
                ptr_reg          <= '0;
                wrapped_reg      <= 1'b0;
                trigger_addr_reg <= '0;
                post_cnt_reg     <= post_trigger_count;
            end else begin
                if (store) begin
                    mem_we_reg    <= 1'b1;
                    mem_waddr_reg <= ptr_reg;
                    mem_wdata_reg <= acq_data_in;
                    ptr_reg       <= ptr_reg + 1'b1;
                    if (ptr_reg == '1)
                        wrapped_reg <= 1'b1;
                end
                case (state_reg)
                    ST_ARMED: begin
                        if (store && hit) begin
                            trigger_addr_reg <= ptr_reg;
                            trigger_out_reg  <= 1'b1;
                            state_reg <= (post_cnt_reg == '0) ? ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        // Hits are ignored here. There is no retrigger.
                        if (store) begin
                            post_cnt_reg <= post_cnt_reg - 1'b1;
                            if (post_cnt_reg == A'(1))
                                state_reg <= ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_waddr = mem_waddr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign trigger_out   = trigger_out_reg;
    assign trigger_addr  = trigger_addr_reg;
    assign wrapped       = wrapped_reg;
    assign busy          = (state_reg == ST_ARMED) || (state_reg == ST_POST);
    assign irq           = (state_reg == ST_DONE);
endmodule

// File: tb/tb_sld_acq_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sld_acq_capture_ctrl
//   Self-checking bench with a scoreboard for sld_acq_capture_ctrl.
//   - A run-level reference model is updated on each clock edge. It pushes the
//     expected RAM writes and trigger events into queues.
//   - A monitor on the falling edge pops these queues and compares them with
//     the DUT outputs. It also compares the status outputs with the model.
// ----------------------------------------------------------------------------
module tb_sld_acq_capture_ctrl;
    localparam int DB    = 8;
    localparam int TB    = 8;
    localparam int AB    = 7;
    localparam int DEPTH = 1 << AB;

    logic          acq_clk = 1'b0;
    logic          clrn    = 1'b0;
    logic          arm = 1'b0, abort = 1'b0, storage_enable = 1'b1;
    logic [TB-1:0] trigger_mask = '0, trigger_value = '0, acq_trigger_in = '0;
    logic [AB-1:0] post_trigger_count = '0;
    logic [DB-1:0] acq_data_in = '0;
    logic          trigger_out, wrapped, busy, irq;
    logic [AB-1:0] trigger_addr;

    always #5 acq_clk = ~acq_clk;

    sld_acq_capture_ctrl_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) mem_if();

    sld_acq_capture_ctrl #(
        .SLD_DATA_BITS(DB), .SLD_TRIGGER_BITS(TB), .SLD_MEM_ADDRESS_BITS(AB)
    ) dut (
        .acq_clk(acq_clk), .clrn(clrn), .arm(arm), .abort(abort),
        .trigger_mask(trigger_mask), .trigger_value(trigger_value),
        .post_trigger_count(post_trigger_count), .acq_trigger_in(acq_trigger_in),
        .acq_data_in(acq_data_in), .storage_enable(storage_enable), .mem(mem_if),
        .trigger_out(trigger_out), .trigger_addr(trigger_addr), .wrapped(wrapped),
        .busy(busy), .irq(irq)
    );

    // ---------------- run-level reference model ----------------
    typedef struct { int addr; int data; } wr_t;
    wr_t exp_wr[$];
    int  exp_trig[$];
    bit  m_active, m_trig, m_done;
    int  m_n, m_rem, m_taddr;
    int  checks = 0, errors = 0;
    int  last_waddr = -1;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_active = 0; m_trig = 0; m_done = 0; m_n = 0; m_rem = 0; m_taddr = 0;
        exp_wr.delete();
        exp_trig.delete();
    endfunction

    // Applies one clock edge's worth of the inputs currently being driven.
    function automatic void model_step();
        bit  qual;
        wr_t w;
`ifdef SLD_ACQ_STORAGE_QUAL_EN
        qual = storage_enable;
`else
        qual = 1'b1;
`endif
        if (!clrn) return;
        if (abort) begin
            m_active = 0; m_done = 0;
        end else if (arm) begin
            m_active = 1; m_trig = 0; m_done = 0; m_n = 0; m_taddr = 0;
            m_rem = int'(post_trigger_count);
            if (m_rem > DEPTH - 1) m_rem = DEPTH - 1;
        end else if (m_active && qual) begin
            w.addr = m_n % DEPTH;
            w.data = int'(acq_data_in);
            exp_wr.push_back(w);
            if (!m_trig) begin
                if (((acq_trigger_in ^ trigger_value) & trigger_mask) == 0) begin
                    m_trig  = 1;
                    m_taddr = m_n % DEPTH;
                    exp_trig.push_back(m_taddr);
                    if (m_rem == 0) begin m_active = 0; m_done = 1; end
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin m_active = 0; m_done = 1; end
            end
            m_n++;
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge acq_clk) begin
        wr_t w;
        int  t;
        if (clrn) begin
            if (mem_if.mem_we) begin
                last_waddr = int'(mem_if.mem_waddr);
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write actual addr=%0d required=none", mem_if.mem_waddr);
                end else begin
                    w = exp_wr.pop_front();
                    chk("waddr", mem_if.mem_waddr, w.addr);
                    chk("wdata", mem_if.mem_wdata, w.data);
                end
            end
            if (exp_wr.size() != 0) begin
                checks++; errors++;
                $display("FAIL missing_write actual=none required addr=%0d", exp_wr[0].addr);
                exp_wr.delete();
            end
            if (trigger_out) begin
                if (exp_trig.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_trigger actual addr=%0d required=none", trigger_addr);
                end else begin
                    t = exp_trig.pop_front();
                    chk("trigger_out_addr", trigger_addr, t);
                end
            end
            if (exp_trig.size() != 0) begin
                checks++; errors++;
                $display("FAIL missing_trigger actual=none required addr=%0d", exp_trig[0]);
                exp_trig.delete();
            end
            chk("busy", busy, m_active);
            chk("irq", irq, m_done);
            chk("wrapped", wrapped, (m_n >= DEPTH) ? 1 : 0);
            chk("trigger_addr", trigger_addr, m_taddr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge acq_clk);
        model_step();
        #1;
        arm = 1'b0;
        abort = 1'b0;
    endtask

    task automatic sample(input logic [TB-1:0] trg, input logic [DB-1:0] d, input logic en);
        acq_trigger_in = trg;
        acq_data_in    = d;
        storage_enable = en;
        tick();
    endtask

    task automatic start(input logic [TB-1:0] msk, input logic [TB-1:0] val, input int post);
        trigger_mask = msk;
        trigger_value = val;
        post_trigger_count = AB'(post);
        arm = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sample(8'h00, DB'($urandom), 1'b1);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2;
        chk("rst_mem_we", mem_if.mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_trigger_out", trigger_out, 0);
        repeat (3) @(negedge acq_clk);
        #2 clrn = 1'b1;
        @(posedge acq_clk); #1;

        // Trigger at sample index 9, post=4: writes to addr 10..13, then DONE.
        start(8'hFF, 8'hA5, 4);
        for (int i = 0; i < 9; i++) sample(8'h5A, DB'(i), 1'b1);
        sample(8'hA5, 8'h99, 1'b1);
        for (int i = 0; i < 4; i++) sample(8'hA5, DB'(i + 50), 1'b1);
        idle(4);
        chk("t2_trigger_addr", trigger_addr, 9);
        chk("t2_last_waddr", last_waddr, 13);
        chk("t2_irq", irq, 1);
        $display("test basic trigger done checks=%0d", checks);

        // Trigger at sample index 200 with D=128, post=20: wrap, trigger at 72, last write at 92.
        start(8'hFF, 8'hA5, 20);
        for (int i = 0; i < 200; i++) sample(8'h00, DB'($urandom), 1'b1);
        sample(8'hA5, 8'h11, 1'b1);
        for (int i = 0; i < 20; i++) sample(8'h00, DB'($urandom), 1'b1);
        idle(3);
        chk("t3_trigger_addr", trigger_addr, 72);
        chk("t3_wrapped", wrapped, 1);
        chk("t3_last_waddr", last_waddr, 92);
        chk("t3_irq", irq, 1);
        $display("test wrap done checks=%0d", checks);

        // Zero mask with post=0: the first sample is the trigger, and DONE follows one write.
        start(8'h00, 8'h00, 0);
        sample(8'h3C, 8'h77, 1'b1);
        chk("t4_irq", irq, 1);
        chk("t4_trigger_addr", trigger_addr, 0);
        idle(2);
        chk("t4_last_waddr", last_waddr, 0);
        $display("test zero mask done checks=%0d", checks);

`ifdef SLD_ACQ_STORAGE_QUAL_EN
        // A hit on a disabled cycle is ignored. Post samples count only enabled cycles.
        start(8'hFF, 8'h3C, 3);
        sample(8'h3C, 8'h01, 1'b0);
        sample(8'h00, 8'h02, 1'b1);
        sample(8'h3C, 8'h03, 1'b0);
        chk("t5_no_trigger_busy", busy, 1);
        sample(8'h3C, 8'h04, 1'b1);
        for (int i = 0; i < 8; i++) sample(8'h00, DB'(i), 1'(i % 2));
        chk("t5_trigger_addr", trigger_addr, 1);
        chk("t5_last_waddr", last_waddr, 4);
        chk("t5_irq", irq, 1);
        $display("test storage qualifier done checks=%0d", checks);
`endif

        // arm+abort in the same cycle: abort wins. Then arm in POST restarts at address 0.
        storage_enable = 1'b1;
        arm = 1'b1; abort = 1'b1;
        tick();
        idle(2);
        chk("t6_busy_after_abort", busy, 0);
        start(8'hFF, 8'hA5, 10);
        sample(8'h00, 8'h10, 1'b1);
        sample(8'hA5, 8'h11, 1'b1);
        idle(3);
        arm = 1'b1;
        tick();
        chk("t6_irq_restart", irq, 0);
        sample(8'h00, 8'h20, 1'b1);
        idle(1);
        chk("t6_restart_addr", last_waddr, 0);
        abort = 1'b1;
        tick();
        $display("test arm abort done checks=%0d", checks);

        // Asynchronous reset in the middle of POST.
        start(8'hFF, 8'hA5, 30);
        sample(8'hA5, 8'h01, 1'b1);
        idle(4);
        @(negedge acq_clk);
        #2 clrn = 1'b0;
        #1;
        chk("t1_rst_mem_we", mem_if.mem_we, 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_irq", irq, 0);
        chk("t1_rst_trigger_addr", trigger_addr, 0);
        chk("t1_rst_wrapped", wrapped, 0);
        model_reset();
        idle(2);
        @(negedge acq_clk);
        #2 clrn = 1'b1;
        idle(2);
        chk("t1_idle_after_rst", busy, 0);
        $display("test async reset done checks=%0d", checks);

        // Randomized runs.
        for (int r = 0; r < 20; r++) begin
            logic [TB-1:0] msk, val;
            int            sel;
            sel = $urandom_range(0, 4);
            msk = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'hF0 : TB'($urandom);
            val = TB'($urandom);
            start(msk, val, (r % 5 == 0) ? DEPTH - 1 : $urandom_range(0, 40));
            for (int c = 0; c < 250; c++) begin
                arm   = ($urandom_range(0, 199) == 0);
                abort = ($urandom_range(0, 299) == 0);
                sample(($urandom_range(0, 19) == 0) ? val : TB'($urandom), DB'($urandom),
                       ($urandom_range(0, 9) < 7));
            end
            $display("random run %0d done checks=%0d errors=%0d", r, checks, errors);
        end
        abort = 1'b1;
        tick();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
